// File: rtl/quad_counter_if.sv
// Quadrature counter bus: encoder/strobe inputs toward the counter and the
// count, snapshot and status outputs back to the host side.
interface quad_counter_if #(
  parameter int ERR_W = 8
) ();
  logic             enc_a;
  logic             enc_b;
  logic             clear;
  logic             snap;
  logic [31:0]      position;
  logic [31:0]      snapshot;
  logic             step;
  logic             dir;
  logic [ERR_W-1:0] err_cnt;
  logic             ready;

  modport master (
    output enc_a, enc_b, clear, snap,
    input  position, snapshot, step, dir, err_cnt, ready
  );

  modport slave (
    input  enc_a, enc_b, clear, snap,
    output position, snapshot, step, dir, err_cnt, ready
  );
endinterface

// File: rtl/quad_counter.sv
// Quadrature encoder counter: synchronizes and glitch-filters channels A/B,
// decodes Gray-code steps into a signed 32-bit position, counts illegal
// double-bit transitions and provides a host-coherent snapshot register.
module quad_counter #(
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input logic           clk,
  input logic           reset,
  quad_counter_if.slave bus
);

  typedef enum logic {INIT, RUN} stateT;

  localparam logic [4:0] INIT_LAST = 5'(FILT_LEN + 1);
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic             aMeta, aSync, bMeta, bSync;
  stateT            state;
  logic             readyReg;
  logic [4:0]       initCnt;
  logic [3:0]       aCnt, bCnt;
  logic             aFilt, bFilt, aPrev, bPrev;
  logic [31:0]      posReg, posNext, snapReg;
  logic             stepReg, dirReg;
  logic [ERR_W-1:0] errReg;
  logic [1:0]       idxNow, idxPrev, idxDelta;
  logic             moved, badMove, runLegal, runBad, forward;

  // Two-flop synchronizers bring the asynchronous encoder pins into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      aMeta <= 1'b0;
      aSync <= 1'b0;
      bMeta <= 1'b0;
      bSync <= 1'b0;
    end else begin
      aMeta <= bus.enc_a;
      aSync <= aMeta;
      bMeta <= bus.enc_b;
      bSync <= bMeta;
    end
  end

  // INIT waits FILT_LEN+2 cycles so synchronizers and filters settle, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      initCnt  <= 5'd0;
      readyReg <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (initCnt == INIT_LAST) begin
            state    <= RUN;
            readyReg <= 1'b1;
          end else begin
            initCnt <= initCnt + 5'd1;
          end
        end
        RUN: begin
          state    <= RUN;
          readyReg <= 1'b1;
        end
        default: begin
          state    <= INIT;
          readyReg <= 1'b0;
        end
      endcase
    end
  end

  // Glitch filter: a new level is accepted only after FILT_LEN steady cycles;
  // in INIT both filtered and previous levels track the pins so RUN starts quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      aCnt  <= 4'd0;
      bCnt  <= 4'd0;
      aFilt <= 1'b0;
      bFilt <= 1'b0;
      aPrev <= 1'b0;
      bPrev <= 1'b0;
    end else if (state == INIT) begin
      aCnt  <= 4'd0;
      bCnt  <= 4'd0;
      aFilt <= aSync;
      bFilt <= bSync;
      aPrev <= aSync;
      bPrev <= bSync;
    end else begin
      aPrev <= aFilt;
      bPrev <= bFilt;
      if (aSync == aFilt) begin
        aCnt <= 4'd0;
      end else if (aCnt == FILT_LAST) begin
        aFilt <= aSync;
        aCnt  <= 4'd0;
      end else begin
        aCnt <= aCnt + 4'd1;
      end
      if (bSync == bFilt) begin
        bCnt <= 4'd0;
      end else if (bCnt == FILT_LAST) begin
        bFilt <= bSync;
        bCnt  <= 4'd0;
      end else begin
        bCnt <= bCnt + 4'd1;
      end
    end
  end

  // Gray pair mapped to a 2-bit phase; +1 phase is forward, -1 is reverse.
  always_comb begin
    idxNow   = {aFilt, aFilt ^ bFilt};
    idxPrev  = {aPrev, aPrev ^ bPrev};
    idxDelta = idxNow - idxPrev;
    moved    = (aFilt != aPrev) || (bFilt != bPrev);
    badMove  = (aFilt != aPrev) && (bFilt != bPrev);
    runLegal = (state == RUN) && moved && !badMove;
    runBad   = (state == RUN) && badMove;
    forward  = (idxDelta == 2'd1);
    posNext  = posReg;
    if (bus.clear) begin
      posNext = 32'd0;
    end else if (runLegal) begin
      posNext = forward ? posReg + 32'd1 : posReg - 32'd1;
    end
  end

  // Position, snapshot, step/dir and the saturating error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      posReg  <= 32'd0;
      snapReg <= 32'd0;
      stepReg <= 1'b0;
      dirReg  <= 1'b0;
      errReg  <= '0;
    end else begin
      posReg  <= posNext;
      stepReg <= runLegal;
      if (bus.snap) begin
        snapReg <= posReg;
      end
      if (runLegal) begin
        dirReg <= forward;
      end
      if (runBad && (errReg != {ERR_W{1'b1}})) begin
        errReg <= errReg + ERR_W'(1);
      end
    end
  end

  assign bus.position = posReg;
  assign bus.snapshot = snapReg;
  assign bus.step     = stepReg;
  assign bus.dir      = dirReg;
  assign bus.err_cnt  = errReg;
  assign bus.ready    = readyReg;

endmodule

// File: tb/tb_quad_counter.sv
// Directed testbench for quad_counter (FILT_LEN=4, ERR_W=8): table of encoder
// moves with hand-computed results, plus sequences for the multi-cycle cases.
module tb_quad_counter;

  typedef struct {
    logic        a;
    logic        b;
    int          hold;
    int          expN;
    int          expAt;
    logic        expDir;
    logic [31:0] expPos;
  } vecT;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   stepCount  = 0;
  vecT  vecs[14];

  quad_counter_if #(.ERR_W(8)) bus ();

  quad_counter #(.FILT_LEN(4), .ERR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Counts every step pulse, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.step === 1'b1) stepCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int hold,
                               output int stepN, output int stepAt);
    bus.enc_a = a;
    bus.enc_b = b;
    stepN  = 0;
    stepAt = -1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        stepN++;
        if (stepAt < 0) stepAt = k;
      end
    end
  endtask

  task automatic pulse(input logic c, input logic s);
    bus.clear = c;
    bus.snap  = s;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.snap  = 1'b0;
  endtask

  initial begin
    int         n;
    int         at;
    int         base;
    int         idx;
    logic       lvl;
    logic [1:0] fwdSeq[4];

    fwdSeq[0] = 2'b00;
    fwdSeq[1] = 2'b01;
    fwdSeq[2] = 2'b11;
    fwdSeq[3] = 2'b10;

    // Starting from filtered 11, pos 0: four forward, six reverse, then glitches.
    vecs[0]  = '{1'b1, 1'b0, 20, 1,  7, 1'b1, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 20, 1,  7, 1'b1, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 20, 1,  7, 1'b1, 32'd3};
    vecs[3]  = '{1'b1, 1'b1, 20, 1,  7, 1'b1, 32'd4};
    vecs[4]  = '{1'b0, 1'b1, 20, 1,  7, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 20, 1,  7, 1'b0, 32'd2};
    vecs[6]  = '{1'b1, 1'b0, 20, 1,  7, 1'b0, 32'd1};
    vecs[7]  = '{1'b1, 1'b1, 20, 1,  7, 1'b0, 32'd0};
    vecs[8]  = '{1'b0, 1'b1, 20, 1,  7, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 1'b0, 20, 1,  7, 1'b0, 32'hFFFF_FFFE};
    vecs[10] = '{1'b1, 1'b0,  3, 0, -1, 1'b0, 32'hFFFF_FFFE};
    vecs[11] = '{1'b0, 1'b0, 20, 0, -1, 1'b0, 32'hFFFF_FFFE};
    vecs[12] = '{1'b1, 1'b0,  4, 0, -1, 1'b0, 32'hFFFF_FFFE};
    vecs[13] = '{1'b0, 1'b0, 20, 2,  3, 1'b1, 32'hFFFF_FFFE};

    reset     = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    bus.clear = 1'b0;
    bus.snap  = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst position", bus.position, 32'd0);
    checkOutput("rst snapshot", bus.snapshot, 32'd0);
    checkOutput("rst step", 32'(bus.step), 32'd0);
    checkOutput("rst dir", 32'(bus.dir), 32'd0);
    checkOutput("rst err_cnt", 32'(bus.err_cnt), 32'd0);
    checkOutput("rst ready", 32'(bus.ready), 32'd0);

    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("init ready low after 5", 32'(bus.ready), 32'd0);
    @(negedge clk);
    checkOutput("init ready high after 6", 32'(bus.ready), 32'd1);
    checkOutput("init position", bus.position, 32'd0);
    checkOutput("init err_cnt", 32'(bus.err_cnt), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("init no step", 32'(stepCount), 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hold, n, at);
      checkOutput($sformatf("vec%0d steps", i), 32'(n), 32'(vecs[i].expN));
      checkOutput($sformatf("vec%0d step latency", i), 32'(at), 32'(vecs[i].expAt));
      checkOutput($sformatf("vec%0d dir", i), 32'(bus.dir), 32'(vecs[i].expDir));
      checkOutput($sformatf("vec%0d position", i), bus.position, vecs[i].expPos);
    end

    // Both channels flip together: 300 illegal transitions, count saturates.
    base = stepCount;
    for (int i = 0; i < 300; i++) begin
      lvl = (i % 2 == 0);
      applyStimulus(lvl, lvl, 8, n, at);
      if (i == 99) checkOutput("err_cnt after 100", 32'(bus.err_cnt), 32'd100);
    end
    checkOutput("err_cnt saturated", 32'(bus.err_cnt), 32'd255);
    checkOutput("illegal position", bus.position, 32'hFFFF_FFFE);
    checkOutput("illegal no step", 32'(stepCount - base), 32'd0);
    checkOutput("illegal dir kept", 32'(bus.dir), 32'd1);

    // Clear alone zeroes position but not the error count.
    pulse(1'b1, 1'b0);
    checkOutput("clear position", bus.position, 32'd0);
    checkOutput("clear keeps err_cnt", 32'(bus.err_cnt), 32'd255);

    // Ten forward steps from 00 land on 11 with position 10.
    base = stepCount;
    idx  = 0;
    for (int i = 0; i < 10; i++) begin
      idx = (idx + 1) % 4;
      applyStimulus(fwdSeq[idx][1], fwdSeq[idx][0], 10, n, at);
    end
    checkOutput("ten steps count", 32'(stepCount - base), 32'd10);
    checkOutput("ten steps position", bus.position, 32'd10);

    // Clear and snap in the very cycle the forward step 11->10 is decoded.
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("coinc pre step", 32'(bus.step), 32'd0);
    pulse(1'b1, 1'b1);
    checkOutput("coinc step", 32'(bus.step), 32'd1);
    checkOutput("coinc dir", 32'(bus.dir), 32'd1);
    checkOutput("coinc snapshot", bus.snapshot, 32'd10);
    checkOutput("coinc position", bus.position, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("coinc position held", bus.position, 32'd0);

    // Snap alone after one more forward step.
    applyStimulus(1'b0, 1'b0, 10, n, at);
    checkOutput("step after clear", bus.position, 32'd1);
    pulse(1'b0, 1'b1);
    checkOutput("snap alone", bus.snapshot, 32'd1);

    // Positive wrap from 0x7FFFFFFF.
    force dut.posReg = 32'h7FFF_FFFF;
    @(negedge clk);
    release dut.posReg;
    @(negedge clk);
    checkOutput("preload position", bus.position, 32'h7FFF_FFFF);
    applyStimulus(1'b0, 1'b1, 10, n, at);
    checkOutput("wrap position", bus.position, 32'h8000_0000);
    checkOutput("wrap dir", 32'(bus.dir), 32'd1);

    // Reset mid-filter: the pending level must not produce a step afterwards.
    applyStimulus(1'b1, 1'b1, 3, n, at);
    checkOutput("midrst pre steps", 32'(n), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = stepCount;
    repeat (30) @(negedge clk);
    checkOutput("midrst no step", 32'(stepCount - base), 32'd0);
    checkOutput("midrst ready", 32'(bus.ready), 32'd1);
    checkOutput("midrst position", bus.position, 32'd0);
    checkOutput("midrst snapshot", bus.snapshot, 32'd0);
    checkOutput("midrst err_cnt", 32'(bus.err_cnt), 32'd0);
    checkOutput("midrst dir", 32'(bus.dir), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quad_counter.md
QUAD_COUNTER -- requirements
Module: quad_counter

Interface
REQ-001 Parameter FILT_LEN, default 4, is the number of consecutive clk cycles a synchronized input must hold a new level before it is accepted (legal range 1..15).
REQ-002 Parameter ERR_W, default 8, is the width of the saturating illegal-transition counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock (CLOCK_50).
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-007 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-008 clear  input  1  one-cycle pulse that zeroes position.
REQ-009 snap  input  1  one-cycle pulse that latches position into snapshot (SPI read-coherency strobe).
REQ-010 position  output  32  signed running count in two's complement.
REQ-011 snapshot  output  32  position value captured at the last snap.
REQ-012 step  output  1  one-cycle pulse on each accepted legal transition.
REQ-013 dir  output  1  direction of the last legal step: 1 = forward, 0 = reverse.
REQ-014 err_cnt  output  ERR_W  count of illegal transitions, saturating.
REQ-015 ready  output  1  high once the block is in RUN.

Function
REQ-016 Each of enc_a and enc_b SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Glitch filter, per channel, in RUN:
- When the synchronized level differs from the filtered level, a per-channel counter SHALL increment each cycle.
- When the levels are equal, that counter SHALL return to 0.
- The filtered level SHALL take the new value on the edge where the counter reaches FILT_LEN, and the counter SHALL clear on that edge.
REQ-018 The state machine SHALL have two states, INIT and RUN.
- Reset enters INIT.
- INIT lasts exactly FILT_LEN+2 cycles, then the block moves to RUN.
- In INIT, the filtered levels SHALL copy the synchronized levels every cycle.
- In INIT, no step, no position change and no err_cnt change SHALL occur.
- ready is 0 in INIT and 1 in RUN.
REQ-019 Decoding SHALL compare the filtered pair {a,b} with its value on the previous cycle, in RUN only:
- 00->01->11->10->00 is forward: position +1, dir=1.
- The reverse sequence is reverse: position -1, dir=0.
- No change: no action.
REQ-020 An illegal transition is both filtered bits changing in the same cycle. It SHALL:
- leave position and dir unchanged;
- produce no step;
- increment err_cnt, which holds at 2^ERR_W-1 once reached.
REQ-021 position SHALL wrap modulo 2^32: 0x7FFFFFFF +1 -> 0x80000000, and 0x00000000 -1 -> 0xFFFFFFFF.
REQ-022 step, dir and position SHALL update on the clk edge following the filtered-level change. End-to-end latency from the first sampling edge that sees a new enc level is 2+FILT_LEN+1 cycles.
REQ-023 clear SHALL set position to 0 on the next edge and takes priority over a simultaneous legal step. step and dir still reflect that step.
REQ-024 snap SHALL load snapshot with the registered position value present in the snap cycle, i.e. the pre-step and pre-clear value when a step or clear coincides with it.
REQ-025 clear and snap in INIT SHALL be honoured identically to RUN.
REQ-026 err_cnt SHALL be cleared only by reset, not by clear.

Reset
REQ-027 A synchronous reset SHALL drive all of the following to 0 and enter INIT: position, snapshot, step, dir, err_cnt, ready, filter counters, synchronizers and filtered levels.
REQ-028 Reset asserted mid-operation SHALL abandon any partially filtered edge. No step SHALL be emitted for an encoder level already present when reset is released.

Verification
REQ-029 Reset, hold enc_a=1, enc_b=1, release reset -> ready rises after FILT_LEN+2=6 cycles, with position=0, err_cnt=0 and no step.
REQ-030 In RUN (FILT_LEN=4), drive 4 forward Gray steps, each held 20 cycles -> 4 step pulses, each 7 cycles after its edge, dir=1, position=4. Then 6 reverse steps -> position=0xFFFFFFFE.
REQ-031 Glitch: a 3-cycle pulse on enc_a -> no step, position unchanged. A 4-cycle pulse -> the filtered level toggles.
REQ-032 Change enc_a and enc_b on the same edge from 00 to 11, 300 times -> position unchanged and err_cnt saturates at 255.
REQ-033 With position=10, assert clear and snap in the same cycle as a forward step -> snapshot=10, position=0, step=1.
REQ-034 Preload position to 0x7FFFFFFF via steps, or force it in simulation, then apply one forward step -> position=0x80000000.
